ysyx_24080006_icache: RTL and testbench

//  Direct-mapped, read-only instruction cache between the IFU AXI read master and the memory crossbar.

---
 rtl/ysyx_24080006_icache.sv | 172 +++++++++++++++++
 tb/tb_ysyx_24080006_icache.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24080006_icache.sv
// Direct-mapped read-only instruction cache: single-beat fetches on the IFU side,
// whole-line INCR refills (or single-beat bypass reads) on the memory side.
module ysyx_24080006_icache #(
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned NUM_LINES  = 16,
  parameter logic [31:0] CACHE_LO   = 32'ha000_0000,
  parameter logic [31:0] CACHE_HI   = 32'ha1ff_ffff
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] s_araddr,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rlast,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  output logic [3:0]  m_arid,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast,
  input  logic        m_rvalid,
  output logic        m_rready
);

  localparam int unsigned LINE_WORDS = LINE_BYTES / 4;
  localparam int unsigned OFS        = $clog2(LINE_BYTES);
  localparam int unsigned IDX        = $clog2(NUM_LINES);
  localparam int unsigned TAG_W      = 32 - OFS - IDX;
  localparam int unsigned WIDX       = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, REFILL_AR, REFILL_R, BYPASS_AR, BYPASS_R, RESP
  } state_t;

  state_t            state, state_n;
  logic [31:0]       addr_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]  tag_arr  [NUM_LINES];
  logic [31:0]       data_arr [NUM_LINES][LINE_WORDS];
  logic [WIDX-1:0]   beat_cnt;
  logic              beat_err;
  logic              flush_pending;
  logic [31:0]       rdata_q;
  logic [1:0]        rresp_q;

  logic [IDX-1:0]    index;
  logic [TAG_W-1:0]  tag;
  logic [WIDX-1:0]   word_off;
  logic              in_range;
  logic              hit;
  logic              err_now;
  logic              install_ok;

  assign index      = addr_q[OFS+IDX-1:OFS];
  assign tag        = addr_q[31:OFS+IDX];
  assign word_off   = WIDX'(addr_q[OFS-1:0] >> 2);
  assign in_range   = (s_araddr >= CACHE_LO) && (s_araddr <= CACHE_HI);
  assign hit        = valid_q[index] && (tag_arr[index] == tag);
  assign err_now    = beat_err || (m_rresp != 2'b00);
  // A line is only trusted if every beat arrived cleanly and no fence.i raced the refill.
  assign install_ok = !err_now && (beat_cnt == WIDX'(LINE_WORDS - 1)) && !flush_pending;

  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;
  assign s_rlast   = 1'b1;
  assign s_rvalid  = (state == RESP);
  assign m_arsize  = 3'h2;
  assign m_arburst = 2'h1;
  assign m_arid    = 4'h0;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    s_arready = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    m_araddr  = addr_q;
    m_arlen   = 8'd0;
    case (state)
      IDLE: begin
        s_arready = 1'b1;
        if (s_arvalid) state_n = in_range ? LOOKUP : BYPASS_AR;
      end
      LOOKUP: state_n = hit ? RESP : REFILL_AR;
      REFILL_AR: begin
        m_arvalid = 1'b1;
        m_araddr  = {addr_q[31:OFS], {OFS{1'b0}}};
        m_arlen   = 8'(LINE_WORDS - 1);
        if (m_arready) state_n = REFILL_R;
      end
      REFILL_R: begin
        m_rready = 1'b1;
        if (m_rvalid && m_rlast) state_n = RESP;
      end
      BYPASS_AR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_n = BYPASS_R;
      end
      BYPASS_R: begin
        m_rready = 1'b1;
        if (m_rvalid) state_n = RESP;
      end
      RESP: if (s_rready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q        <= '0;
      valid_q       <= '0;
      beat_cnt      <= '0;
      beat_err      <= 1'b0;
      flush_pending <= 1'b0;
      rdata_q       <= '0;
      rresp_q       <= 2'b00;
    end else begin
      if (flush)                                flush_pending <= 1'b1;
      else if (state == IDLE && flush_pending)  flush_pending <= 1'b0;
      if (state == IDLE) begin
        if (flush_pending) valid_q <= '0;
        if (s_arvalid)     addr_q  <= s_araddr;
      end
      case (state)
        LOOKUP: if (hit) begin
          rdata_q <= data_arr[index][word_off];
          rresp_q <= 2'b00;
        end
        REFILL_AR: if (m_arready) begin
          beat_cnt <= '0;
          beat_err <= 1'b0;
        end
        REFILL_R: if (m_rvalid) begin
          beat_cnt <= beat_cnt + 1'b1;
          beat_err <= err_now;
          if (beat_cnt == word_off) rdata_q <= m_rdata;
          if (m_rlast) begin
            rresp_q <= err_now ? 2'b10 : 2'b00;
            if (install_ok) valid_q[index] <= 1'b1;
          end
        end
        BYPASS_R: if (m_rvalid) begin
          rdata_q <= m_rdata;
          rresp_q <= m_rresp;
        end
        default: ;
      endcase
    end
  end

  // Arrays carry no reset; the valid bits alone decide whether their contents are used.
  always_ff @(posedge clock) begin
    if (!reset && state == REFILL_R && m_rvalid) begin
      data_arr[index][beat_cnt] <= m_rdata;
      if (m_rlast && install_ok) tag_arr[index] <= tag;
    end
  end

endmodule

// File: tb/tb_ysyx_24080006_icache.sv
// Directed bench for the instruction cache: a burst-capable memory model whose
// word at address A is A + 0x1000_0000, plus a table of fetches with hand-computed results.
module tb_ysyx_24080006_icache;

  logic        clock, reset, flush;
  logic [31:0] s_araddr;
  logic        s_arvalid, s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast, s_rvalid, s_rready;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic [3:0]  m_arid;
  logic        m_arvalid, m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast, m_rvalid, m_rready;

  ysyx_24080006_icache dut (
    .clock(clock), .reset(reset), .flush(flush),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arid(m_arid), .m_arvalid(m_arvalid),
    .m_arready(m_arready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Memory model: samples handshakes before the edge, updates its drives just after it.
  int          ar_count = 0;
  int          err_beat = -1;
  logic [31:0] last_araddr = '0;
  logic [7:0]  last_arlen = '0;
  logic [31:0] burst_addr = '0;
  int          burst_len = 0;
  int          beat_idx = 0;

  task automatic driveBeat();
    m_rvalid = 1'b1;
    m_rdata  = burst_addr + 32'(beat_idx * 4) + 32'h1000_0000;
    m_rresp  = (beat_idx == err_beat) ? 2'b10 : 2'b00;
    m_rlast  = (beat_idx == burst_len);
  endtask

  initial begin
    logic rst_s, ar_s, r_s;
    logic [31:0] addr_s;
    logic [7:0] len_s;
    m_arready = 1'b1; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00; m_rlast = 1'b0;
    forever begin
      @(negedge clock);
      rst_s  = reset;
      ar_s   = m_arvalid && m_arready;
      r_s    = m_rvalid && m_rready;
      addr_s = m_araddr;
      len_s  = m_arlen;
      @(posedge clock);
      #1;
      if (rst_s) begin
        m_rvalid = 1'b0; m_rlast = 1'b0; m_arready = 1'b1;
      end else if (ar_s) begin
        ar_count++;
        last_araddr = addr_s;
        last_arlen  = len_s;
        burst_addr  = addr_s;
        burst_len   = int'(len_s);
        beat_idx    = 0;
        m_arready   = 1'b0;
        driveBeat();
      end else if (r_s) begin
        if (beat_idx == burst_len) begin
          m_rvalid = 1'b0; m_rlast = 1'b0; m_arready = 1'b1;
        end else begin
          beat_idx++;
          driveBeat();
        end
      end
    end
  end

  // One fetch: returns data/resp, cycles from AR handshake to rvalid, and memory ARs issued.
  task automatic applyStimulus(input logic [31:0] addr, input int hold, input logic [31:0] hold_exp,
                               output logic [31:0] data, output logic [1:0] resp,
                               output int lat, output int ars);
    int n;
    int ar0;
    ar0 = ar_count;
    s_rready = (hold == 0);
    s_araddr = addr;
    s_arvalid = 1'b1;
    n = 0;
    while (!s_arready && n < 50) begin
      @(negedge clock);
      n++;
    end
    checkOutput("arready_timeout", 32'(n >= 50), 32'd0);
    @(posedge clock);
    #1;
    s_arvalid = 1'b0;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!s_rvalid && lat < 200);
    checkOutput("rvalid_timeout", 32'(lat >= 200), 32'd0);
    data = s_rdata;
    resp = s_rresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      checkOutput("bp_rvalid", 32'(s_rvalid), 32'd1);
      checkOutput("bp_rdata", s_rdata, hold_exp);
    end
    s_rready = 1'b1;
    @(negedge clock);
    checkOutput("rvalid_drop", 32'(s_rvalid), 32'd0);
    ars = ar_count - ar0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
    int          ars;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    int          lat;
  } vec_t;

  task automatic runVec(input vec_t v, input string nm);
    logic [31:0] d;
    logic [1:0]  r;
    int          lat, ars;
    applyStimulus(v.addr, 0, 32'h0, d, r, lat, ars);
    checkOutput({nm, "_data"}, d, v.data);
    checkOutput({nm, "_resp"}, 32'(r), 32'(v.resp));
    checkOutput({nm, "_ars"}, 32'(ars), 32'(v.ars));
    if (v.ars > 0) begin
      checkOutput({nm, "_araddr"}, last_araddr, v.araddr);
      checkOutput({nm, "_arlen"}, 32'(last_arlen), 32'(v.arlen));
    end
    if (v.lat >= 0) checkOutput({nm, "_lat"}, 32'(lat), 32'(v.lat));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[14];
    logic [31:0] d;
    logic [1:0]  r;
    int          lat, ars, wn;

    vecs[0]  = '{32'ha000_0008, 32'hb000_0008, 2'd0, 1, 32'ha000_0000, 8'd3, -1};
    vecs[1]  = '{32'ha000_0004, 32'hb000_0004, 2'd0, 0, 32'h0,         8'd0,  2};
    vecs[2]  = '{32'ha000_000c, 32'hb000_000c, 2'd0, 0, 32'h0,         8'd0,  2};
    vecs[3]  = '{32'ha000_0108, 32'hb000_0108, 2'd0, 1, 32'ha000_0100, 8'd3, -1};
    vecs[4]  = '{32'ha000_0008, 32'hb000_0008, 2'd0, 1, 32'ha000_0000, 8'd3, -1};
    vecs[5]  = '{32'ha000_0000, 32'hb000_0000, 2'd0, 0, 32'h0,         8'd0,  2};
    vecs[6]  = '{32'h3000_0010, 32'h4000_0010, 2'd0, 1, 32'h3000_0010, 8'd0, -1};
    vecs[7]  = '{32'h3000_0010, 32'h4000_0010, 2'd0, 1, 32'h3000_0010, 8'd0, -1};
    vecs[8]  = '{32'ha1ff_fffc, 32'hb1ff_fffc, 2'd0, 1, 32'ha1ff_fff0, 8'd3, -1};
    vecs[9]  = '{32'ha1ff_fff0, 32'hb1ff_fff0, 2'd0, 0, 32'h0,         8'd0,  2};
    vecs[10] = '{32'ha200_0000, 32'hb200_0000, 2'd0, 1, 32'ha200_0000, 8'd0, -1};
    vecs[11] = '{32'h9fff_fffc, 32'hafff_fffc, 2'd0, 1, 32'h9fff_fffc, 8'd0, -1};
    vecs[12] = '{32'ha000_0010, 32'hb000_0010, 2'd0, 1, 32'ha000_0010, 8'd3, -1};
    vecs[13] = '{32'ha000_0018, 32'hb000_0018, 2'd0, 0, 32'h0,         8'd0,  2};

    reset = 1'b1; flush = 1'b0; s_arvalid = 1'b0; s_araddr = '0; s_rready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("rst_arready", 32'(s_arready), 32'd1);
    checkOutput("rst_rvalid", 32'(s_rvalid), 32'd0);
    checkOutput("rst_m_arvalid", 32'(m_arvalid), 32'd0);
    checkOutput("rst_m_rready", 32'(m_rready), 32'd0);
    checkOutput("rst_rresp", 32'(s_rresp), 32'd0);
    checkOutput("rst_rlast", 32'(s_rlast), 32'd1);
    checkOutput("arsize", 32'(m_arsize), 32'd2);
    checkOutput("arburst", 32'(m_arburst), 32'd1);
    checkOutput("arid", 32'(m_arid), 32'd0);

    for (int i = 0; i < 14; i++) runVec(vecs[i], $sformatf("v%0d", i));

    // Errored refill: beat 1 SLVERR, requested word 0 is still delivered, line stays invalid.
    err_beat = 1;
    runVec('{32'ha000_0040, 32'hb000_0040, 2'd2, 1, 32'ha000_0040, 8'd3, -1}, "err");
    err_beat = -1;
    runVec('{32'ha000_0040, 32'hb000_0040, 2'd0, 1, 32'ha000_0040, 8'd3, -1}, "err_refetch");

    applyStimulus(32'ha000_0044, 5, 32'hb000_0044, d, r, lat, ars);
    checkOutput("bp_data", d, 32'hb000_0044);
    checkOutput("bp_ars", 32'(ars), 32'd0);

    // fence.i during REFILL_R: the fetch completes but the line must not be installed.
    fork
      applyStimulus(32'ha000_0054, 0, 32'h0, d, r, lat, ars);
      begin
        wn = 0;
        while (!m_rready && wn < 100) begin
          @(negedge clock);
          wn++;
        end
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
      end
    join
    checkOutput("fl_wait", 32'(wn >= 100), 32'd0);
    checkOutput("fl_data", d, 32'hb000_0054);
    checkOutput("fl_resp", 32'(r), 32'd0);
    checkOutput("fl_ars", 32'(ars), 32'd1);
    runVec('{32'ha000_0050, 32'hb000_0050, 2'd0, 1, 32'ha000_0050, 8'd3, -1}, "fl_refetch");
    runVec('{32'ha000_005c, 32'hb000_005c, 2'd0, 0, 32'h0, 8'd0, 2}, "fl_hit");

    // Request accepted on the very cycle the pending flush clears the valid bits.
    flush = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    runVec('{32'ha000_0058, 32'hb000_0058, 2'd0, 1, 32'ha000_0050, 8'd3, -1}, "fl_idle");

    // Reset in the middle of a refill.
    s_araddr = 32'ha000_0068;
    s_arvalid = 1'b1;
    wn = 0;
    while (!s_arready && wn < 50) begin
      @(negedge clock);
      wn++;
    end
    @(posedge clock);
    #1 s_arvalid = 1'b0;
    wn = 0;
    while (!(m_rready && m_rvalid) && wn < 50) begin
      @(negedge clock);
      wn++;
    end
    checkOutput("mr_wait", 32'(wn >= 50), 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checkOutput("mr_arready", 32'(s_arready), 32'd1);
    checkOutput("mr_rvalid", 32'(s_rvalid), 32'd0);
    checkOutput("mr_m_arvalid", 32'(m_arvalid), 32'd0);
    checkOutput("mr_m_rready", 32'(m_rready), 32'd0);
    checkOutput("mr_rresp", 32'(s_rresp), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    runVec('{32'ha000_0068, 32'hb000_0068, 2'd0, 1, 32'ha000_0060, 8'd3, -1}, "mr_refetch");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
